// File: rtl/heartbeat_scheduler.sv
// Heartbeat request sequencer: issues sequenced heartbeat requests, tracks replies,
// retries on timeout and pulses lost after MAX_MISS consecutive misses.
module heartbeat_scheduler #(
    parameter int SEQ_W      = 8,
    parameter int INTERVAL_W = 16,
    parameter int TIMEOUT_W  = 12,
    parameter int MAX_MISS   = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [INTERVAL_W-1:0]         interval,
    input  logic [TIMEOUT_W-1:0]          timeout,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [SEQ_W-1:0]              req_seq,
    input  logic                          ack_valid,
    input  logic [SEQ_W-1:0]              ack_seq,
    output logic                          alive,
    output logic                          lost,
    output logic [$clog2(MAX_MISS+1)-1:0] miss_count
);

    localparam int MW = $clog2(MAX_MISS + 1);
    localparam logic [MW-1:0] MISS_LIMIT = MW'(MAX_MISS);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_ACK,
        WAIT_INTERVAL
    } state_t;

    state_t                state;
    logic [TIMEOUT_W-1:0]  ack_timer;
    logic [INTERVAL_W-1:0] int_timer;
    logic                  issued;
    logic [TIMEOUT_W-1:0]  eff_timeout;
    logic [INTERVAL_W-1:0] eff_interval;
    logic                  ack_match;

    always_comb begin
        eff_timeout  = (timeout == '0) ? TIMEOUT_W'(1) : timeout;
        eff_interval = (interval == '0) ? INTERVAL_W'(1) : interval;
        ack_match    = ack_valid && (ack_seq == req_seq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_valid  <= 1'b0;
            req_seq    <= '0;
            alive      <= 1'b0;
            lost       <= 1'b0;
            miss_count <= '0;
            ack_timer  <= '0;
            int_timer  <= '0;
            issued     <= 1'b0;
        end else begin
            lost <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= REQUEST;
                        req_valid <= 1'b1;
                        // Only the very first request after reset reuses the current seq.
                        if (issued) req_seq <= req_seq + SEQ_W'(1);
                    end else begin
                        alive      <= 1'b0;
                        miss_count <= '0;
                    end
                end
                REQUEST: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        issued    <= 1'b1;
                        if (enable) begin
                            state     <= WAIT_ACK;
                            ack_timer <= eff_timeout;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (!enable) begin
                        state      <= IDLE;
                        alive      <= 1'b0;
                        miss_count <= '0;
                    end else if (ack_match) begin
                        alive      <= 1'b1;
                        miss_count <= '0;
                        // The ack cycle itself counts toward the interval.
                        if (eff_interval == INTERVAL_W'(1)) begin
                            state     <= REQUEST;
                            req_valid <= 1'b1;
                            req_seq   <= req_seq + SEQ_W'(1);
                        end else begin
                            state     <= WAIT_INTERVAL;
                            int_timer <= eff_interval - INTERVAL_W'(1);
                        end
                    end else if (ack_timer <= TIMEOUT_W'(1)) begin
                        if (miss_count + MW'(1) == MISS_LIMIT) begin
                            lost       <= 1'b1;
                            alive      <= 1'b0;
                            miss_count <= '0;
                            state      <= WAIT_INTERVAL;
                            int_timer  <= eff_interval;
                        end else begin
                            miss_count <= miss_count + MW'(1);
                            state      <= REQUEST;
                            req_valid  <= 1'b1;
                            req_seq    <= req_seq + SEQ_W'(1);
                        end
                    end else begin
                        ack_timer <= ack_timer - TIMEOUT_W'(1);
                    end
                end
                WAIT_INTERVAL: begin
                    if (!enable) begin
                        state      <= IDLE;
                        alive      <= 1'b0;
                        miss_count <= '0;
                    end else if (int_timer <= INTERVAL_W'(1)) begin
                        state     <= REQUEST;
                        req_valid <= 1'b1;
                        req_seq   <= req_seq + SEQ_W'(1);
                    end else begin
                        int_timer <= int_timer - INTERVAL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heartbeat_scheduler.sv
// Directed bench for heartbeat_scheduler (SEQ_W=2 so sequence wrap is reachable).
module tb_heartbeat_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] interval;
    logic [11:0] timeout;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_seq;
    logic        ack_valid;
    logic [1:0]  ack_seq;
    logic        alive;
    logic        lost;
    logic [1:0]  miss_count;

    int total = 0;
    int bad   = 0;

    heartbeat_scheduler #(
        .SEQ_W(2),
        .INTERVAL_W(16),
        .TIMEOUT_W(12),
        .MAX_MISS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .interval(interval),
        .timeout(timeout),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_seq(req_seq),
        .ack_valid(ack_valid),
        .ack_seq(ack_seq),
        .alive(alive),
        .lost(lost),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, {31'd0, req_valid}, 32'd0);
        check({tag, "_seq"},   {30'd0, req_seq},   32'd0);
        check({tag, "_alive"}, {31'd0, alive},     32'd0);
        check({tag, "_lost"},  {31'd0, lost},      32'd0);
        check({tag, "_miss"},  {30'd0, miss_count}, 32'd0);
    endtask

    task automatic expect_req(input string tag, input logic [1:0] seq);
        check({tag, "_valid"}, {31'd0, req_valid}, 32'd1);
        check({tag, "_seq"},   {30'd0, req_seq},   {30'd0, seq});
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; interval = 16'd4; timeout = 12'd3;
        req_ready = 1'b1; ack_valid = 1'b0; ack_seq = 2'd0;

        // Basic round
        do_reset();
        check_reset_state("rst0");
        enable = 1'b1;
        step(1);
        expect_req("basic_req0", 2'd0);               // handshake T
        step(1);
        check("basic_drop", {31'd0, req_valid}, 32'd0);
        step(1);                                      // T+2
        ack_valid = 1'b1; ack_seq = 2'd0;
        step(1);                                      // A+1
        ack_valid = 1'b0;
        check("basic_alive", {31'd0, alive}, 32'd1);
        step(2);                                      // A+3
        check("basic_gap", {31'd0, req_valid}, 32'd0);
        step(1);                                      // A+4
        expect_req("basic_req1", 2'd1);

        // Timeout and loss
        do_reset();
        check_reset_state("rst1");
        enable = 1'b1;
        step(1);
        expect_req("loss_req0", 2'd0);
        step(3);
        check("loss_wait0", {31'd0, req_valid}, 32'd0);
        step(1);
        expect_req("loss_req1", 2'd1);
        check("loss_miss1", {30'd0, miss_count}, 32'd1);
        step(4);
        expect_req("loss_req2", 2'd2);
        check("loss_miss2", {30'd0, miss_count}, 32'd2);
        step(3);
        check("loss_prelost", {31'd0, lost}, 32'd0);
        step(1);                                      // T2+4
        check("loss_lost",  {31'd0, lost},       32'd1);
        check("loss_alive", {31'd0, alive},      32'd0);
        check("loss_miss0", {30'd0, miss_count}, 32'd0);
        check("loss_novld", {31'd0, req_valid},  32'd0);
        step(1);
        check("loss_pulse", {31'd0, lost}, 32'd0);
        step(2);
        check("loss_gap", {31'd0, req_valid}, 32'd0);
        step(1);
        expect_req("loss_req3", 2'd3);

        // Wrong-seq ack is ignored; retry wraps seq to 0
        step(1);                                      // T+1
        ack_valid = 1'b1; ack_seq = 2'd2;
        step(1);
        ack_valid = 1'b0;
        step(2);                                      // T+4
        expect_req("wrong_retry", 2'd0);
        check("wrong_miss", {30'd0, miss_count}, 32'd1);

        // Matching ack on the last window cycle is accepted
        step(3);                                      // T+3
        ack_valid = 1'b1; ack_seq = 2'd0;
        step(1);                                      // A+1
        ack_valid = 1'b0;
        check("edge_alive", {31'd0, alive},      32'd1);
        check("edge_noretry", {31'd0, req_valid}, 32'd0);
        check("edge_miss", {30'd0, miss_count},  32'd0);
        step(2);
        check("edge_gap", {31'd0, req_valid}, 32'd0);
        step(1);                                      // A+4
        req_ready = 1'b0;
        expect_req("edge_req1", 2'd1);

        // Backpressure with enable dropped mid-stall
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (i == 2) enable = 1'b0;
            expect_req($sformatf("stall%0d", i), 2'd1);
        end
        req_ready = 1'b1;                             // handshake this cycle
        step(1);
        check("dis_drop", {31'd0, req_valid}, 32'd0);
        step(1);
        check("dis_idle",  {31'd0, req_valid}, 32'd0);
        check("dis_alive", {31'd0, alive},     32'd0);

        // Zero interval and timeout behave as 1
        do_reset();
        interval = 16'd0; timeout = 12'd0;
        enable = 1'b1;
        step(1);
        expect_req("zero_req0", 2'd0);
        step(1);
        check("zero_wait", {31'd0, req_valid}, 32'd0);
        step(1);
        expect_req("zero_retry", 2'd1);
        check("zero_miss", {30'd0, miss_count}, 32'd1);
        step(1);
        ack_valid = 1'b1; ack_seq = 2'd1;
        step(1);
        ack_valid = 1'b0;
        check("zero_alive", {31'd0, alive}, 32'd1);
        expect_req("zero_next", 2'd2);

        // Mid-run reset during WAIT_ACK
        interval = 16'd4; timeout = 12'd3;
        step(1);
        check("mid_waitack", {31'd0, req_valid}, 32'd0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset_state("mid_rst");
        step(1);
        expect_req("mid_restart", 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/heartbeat_scheduler.md
# heartbeat_scheduler

Controller that sequences the router's heartbeat requester. It periodically asks the requester to emit a heartbeat packet carrying a sequence number, then waits for the matching reply. It retries on timeout and declares the neighbour lost after a configurable number of consecutive misses. It sits in `packet_controller/router` between the router's configuration registers and the heartbeat requester's request port.

## Interface
- `SEQ_W`, 8, width of the heartbeat sequence number
- `INTERVAL_W`, 16, width of the interval setting
- `TIMEOUT_W`, 12, width of the timeout setting
- `MAX_MISS`, 3, consecutive timeouts that declare the neighbour lost (≥1)

Ports:
- `clk`  in  1  clock; every register is updated on its rising edge
- `rst`  in  1  synchronous reset, active-high
- `enable`  in  1  scheduler enable (level)
- `interval`  in  INTERVAL_W  cycles from an accepted reply (or a loss) to the next request; 0 is treated as 1
- `timeout`  in  TIMEOUT_W  reply window after the request handshake; 0 is treated as 1
- `req_valid`  out  1  heartbeat request to the requester
- `req_ready`  in  1  requester accepts the request
- `req_seq`  out  SEQ_W  sequence number of the current request
- `ack_valid`  in  1  heartbeat reply received
- `ack_seq`  in  SEQ_W  sequence number of the reply
- `alive`  out  1  neighbour considered alive (level)
- `lost`  out  1  one-cycle pulse when the neighbour is declared lost
- `miss_count`  out  $clog2(MAX_MISS+1)  current consecutive-miss count

## Operation
- States: IDLE, REQUEST, WAIT_ACK, WAIT_INTERVAL.
- Reset values:
  - state IDLE
  - `req_valid`=0, `req_seq`=0
  - `alive`=0, `lost`=0, `miss_count`=0
  - internal timers 0
- IDLE: when `enable`=1, go to REQUEST. `req_seq` is unchanged on the first request after reset, so the first request uses seq 0.
- REQUEST: `req_valid`=1 with `req_seq` stable. When `req_valid` and `req_ready` are both high, that cycle is the handshake. Go to WAIT_ACK and load the reply timer from `timeout`.
- WAIT_ACK outcomes:
  - Matching reply (`ack_valid`=1 and `ack_seq`==`req_seq`): set `alive`=1, clear `miss_count`, go to WAIT_INTERVAL.
  - Non-matching or unsolicited acks are ignored in every state.
  - Window expires with no matching reply: increment `miss_count`.
    - If the new count is below MAX_MISS: `req_seq`+1, go to REQUEST immediately (retry).
    - If the new count equals MAX_MISS: pulse `lost`, set `alive`=0, clear `miss_count`, go to WAIT_INTERVAL.
- WAIT_INTERVAL: when the interval elapses, `req_seq`+1 and go to REQUEST. Probing continues after a loss.
- `req_seq` wraps modulo 2^SEQ_W.
- `enable`=0:
  - In IDLE, WAIT_ACK or WAIT_INTERVAL: go to IDLE next cycle and clear `alive` and `miss_count`.
  - In REQUEST: `req_valid` is never retracted. Hold until the handshake, then go to IDLE.
- `interval` and `timeout` are sampled when their timers load; changing them mid-count does not affect the running count.

## Timing
- Enable: `enable` high in IDLE at cycle E gives `req_valid`=1 at E+1.
- Reply window: for a handshake at cycle T, acks are accepted in cycles T+1 … T+timeout inclusive.
  - A matching ack at T+timeout is accepted.
  - Ack wins over expiry in the same cycle.
- Retry: with no matching ack, `req_valid`=1 at T+timeout+1 with the incremented seq.
- Loss: on the final miss, `lost`=1 and `alive`=0 in cycle T+timeout+1 only. The next `req_valid` rises at (T+timeout+1)+interval.
- Accepted reply: for a matching ack at cycle A, `alive`=1 from A+1. The next `req_valid` rises at A+interval. With interval=1 this is A+1, skipping WAIT_INTERVAL.
- Handshake: `req_valid` falls in the cycle after the handshake. Back-to-back requests never occur without an intervening WAIT_ACK.
- Reset: `rst` high at any cycle gives reset values at the next edge, aborting any pending request or timer.

## Test plan
- Basic round: reset, then enable=1, interval=4, timeout=3, `req_ready` always 1.
  - Expect `req_valid` one cycle after enable, seq 0.
  - Ack seq 0 two cycles after the handshake → `alive`=1.
  - Next request seq 1 exactly 4 cycles after the ack.
- Timeout and loss: same config, MAX_MISS=3, never ack.
  - Requests with seq 0, 1, 2 spaced timeout+1 cycles apart; `miss_count` steps 1, 2.
  - After the third expiry: `lost` pulses one cycle, `alive`=0.
  - Seq 3 is requested 4 cycles later.
- Boundary acks:
  - Ack with the wrong seq → ignored, timeout still fires.
  - Matching ack exactly at T+timeout → accepted, no retry.
- Backpressure and disable:
  - Hold `req_ready`=0 for 5 cycles → `req_valid` and `req_seq` stable throughout.
  - Drop `enable` during the stall → handshake still completes, then IDLE with `req_valid`=0.
- Wrap and zero settings: SEQ_W=2 over 5 rounds → seq 0, 1, 2, 3, 0. interval=0 and timeout=0 behave as 1.
- Mid-run reset: assert `rst` during WAIT_ACK → all outputs return to reset values next cycle; re-enable restarts at seq 0.
